// File: rtl/flog_issue_ctrl.sv
// flog_issue_ctrl: operand FIFO plus issue/wait/timeout sequencer in front of a bfloat16 log2 core.
module flog_issue_ctrl #(
  parameter int DEPTH = 4,
  parameter int TIMEOUT = 64,
  parameter int EXP_WIDTH = 8,
  parameter int FRACT_WIDTH = 7,
  localparam int W = 1 + EXP_WIDTH + FRACT_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [W-1:0]           in_data_i,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  output logic                   sign_o,
  output logic [EXP_WIDTH-1:0]   exponent_o,
  output logic [FRACT_WIDTH-1:0] fractional_o,
  output logic                   core_valid_o,
  input  logic                   core_s_i,
  input  logic [EXP_WIDTH-1:0]   core_e_i,
  input  logic [FRACT_WIDTH-1:0] core_f_i,
  input  logic                   core_valid_i,
  output logic [W-1:0]           out_data_o,
  output logic                   out_timeout_o,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic                   busy_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(TIMEOUT);
  localparam logic [W-1:0] QNAN = {1'b0, {EXP_WIDTH{1'b1}}, 1'b1, {(FRACT_WIDTH-1){1'b0}}};
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
  state_t state, state_nx;
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count;
  logic [CW-1:0] wait_cnt;
  logic push, pop, hit, expire;
  assign in_ready_o = count != (AW+1)'(DEPTH);
  assign push = in_valid_i & in_ready_o;
  assign hit = state == WAIT && core_valid_i;
  assign expire = state == WAIT && wait_cnt == CW'(TIMEOUT - 1);
  // a core result arriving on the last wait cycle takes priority over the timeout
  assign pop = hit | expire;
  assign {sign_o, exponent_o, fractional_o} = count != '0 ? mem[rd_ptr] : '0;
  assign core_valid_o = state == ISSUE;
  assign busy_o = state != IDLE || count != '0 || out_valid_o;
  always_comb begin
    state_nx = state;
    state_nx = state == IDLE  ? (count != '0 && !out_valid_o ? ISSUE : IDLE)
             : state == ISSUE ? WAIT
             : pop ? IDLE : WAIT;
  end
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= in_data_i;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      wait_cnt <= '0;
      out_valid_o <= 1'b0;
      out_data_o <= '0;
      out_timeout_o <= 1'b0;
    end else begin
      state <= state_nx;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
      wait_cnt <= state == ISSUE ? '0 : state == WAIT ? wait_cnt + 1'b1 : wait_cnt;
      if (pop) begin
        out_data_o <= hit ? {core_s_i, core_e_i, core_f_i} : QNAN;
        out_timeout_o <= !hit;
        out_valid_o <= 1'b1;
      end else if (out_ready_i) begin
        out_valid_o <= 1'b0;
      end
    end
  end
endmodule

// File: doc/flog_issue_ctrl.md
FLOG_ISSUE_CTRL -- requirements
Module: flog_issue_ctrl

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
 DEPTH, 4, operand FIFO entries (power of two, >=2)
 TIMEOUT, 64, max cycles in WAIT before abort (>=8)
 EXP_WIDTH / FRACT_WIDTH, from flog_pkg (8 / 7)
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
 clk  in  1  single clock, all logic on rising edge
 rst  in  1  reset, synchronous, active-high
 in_data_i  in  16  packed bfloat16 operand {sign, exp[7:0], fract[6:0]}
 in_valid_i  in  1  operand valid
 in_ready_o  out  1  operand accepted when in_valid_i & in_ready_o
 sign_o / exponent_o / fractional_o  out  1 / 8 / 7  operand to flog core
 core_valid_o  out  1  one-cycle issue strobe to flog core
 core_s_i / core_e_i / core_f_i  in  1 / 8 / 7  flog core result
 core_valid_i  in  1  flog core result strobe
 out_data_o  out  16  packed bfloat16 result
 out_timeout_o  out  1  result is timeout substitute
 out_valid_o  out  1  result valid, held until accepted
 out_ready_i  in  1  result accepted when out_valid_o & out_ready_i
 busy_o  out  1  any operand queued, in flight, or result pending

Function
REQ-003 Operand FIFO SHALL hold DEPTH entries; in_ready_o = (registered count != DEPTH).
REQ-004 Push SHALL occur on in handshake; pop SHALL occur only on result capture (REQ-009/010); simultaneous push and pop SHALL leave count unchanged, data order preserved.
REQ-005 sign_o/exponent_o/fractional_o SHALL be the FIFO head fields, stable from ISSUE until pop; 0 when empty.
REQ-006 FSM states SHALL be IDLE, ISSUE, WAIT.
REQ-007 IDLE -> ISSUE when count != 0 and out_valid_o == 0 (both registered); else stay.
REQ-008 ISSUE SHALL last exactly one cycle with core_valid_o = 1, then -> WAIT; core_valid_o = 0 in all other states.
REQ-009 WAIT with core_valid_i = 1: capture {core_s_i, core_e_i, core_f_i} into out_data_o, out_timeout_o = 0, out_valid_o = 1 next cycle, pop FIFO, -> IDLE.
REQ-010 WAIT cycle counter SHALL clear on ISSUE and increment each WAIT cycle; when it equals TIMEOUT-1 with core_valid_i = 0: out_data_o = 0x7FC0 (QNaN), out_timeout_o = 1, out_valid_o = 1, pop, -> IDLE.
REQ-011 core_valid_i in the same cycle as timeout SHALL win (REQ-009 path).
REQ-012 core_valid_i outside WAIT SHALL be ignored (late result after timeout discarded, no output change).
REQ-013 out_valid_o SHALL clear the cycle after out handshake; out_data_o/out_timeout_o SHALL hold while out_valid_o = 1.
REQ-014 At most one operand in flight; no issue while a result is unaccepted.
REQ-015 Minimum latency, empty and idle: push at edge N, ISSUE during cycle N+1, result captured on the edge ending the core_valid_i cycle, out_valid_o high the following cycle.
REQ-016 busy_o = (state != IDLE) | (count != 0) | out_valid_o.

Reset
REQ-017 On rst sampled high: state IDLE, count 0, FIFO pointers 0, counter 0, out_valid_o 0, out_data_o 0, out_timeout_o 0, core_valid_o 0, in_ready_o 1 the following cycle.
REQ-018 rst mid-operation SHALL drop queued and in-flight operands; a subsequent core_valid_i SHALL be ignored per REQ-012.

Verification
REQ-019 Single op, core model returns log2: push 0x4000 (2.0) -> one core_valid_o pulse with exponent_o = 0x80, fractional_o = 0; out_data_o = 0x3F80, out_timeout_o = 0.
REQ-020 Burst: push 0x3F80, 0x4080, 0x4100, 0x4180 back-to-back, out_ready_i = 1 -> in_ready_o low after 4th push until first pop; results 0x0000, 0x4000, 0x4040, 0x4080 in order.
REQ-021 Backpressure: out_ready_i = 0 for 20 cycles after first result -> out_data_o held, no second core_valid_o until handshake.
REQ-022 Timeout: core model silent -> out_data_o = 0x7FC0, out_timeout_o = 1 after exactly TIMEOUT WAIT cycles; late core_valid_i ignored.
REQ-023 Race: core_valid_i on the TIMEOUT-1 cycle -> core result output, out_timeout_o = 0.
REQ-024 Reset in WAIT with 3 queued -> busy_o = 0, in_ready_o = 1, no out_valid_o.
